// File: rtl/filter_window_gen.sv
// 3x3 sliding-window generator: two row line buffers feed a window shift register,
// and a registered valid/ready output stage lets the consumer stall the pixel stream.
module filter_window_gen #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_pixel,
    output logic       win_valid,
    input  logic       win_ready,
    output logic [7:0] win [8:0],
    output logic       win_last
);

    localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;

    logic [7:0] lb0_q [IMG_WIDTH];
    logic [7:0] lb1_q [IMG_WIDTH];

    logic [7:0] sr_q  [8:0];
    logic [7:0] sr_d  [8:0];
    logic [7:0] win_q [8:0];
    logic [7:0] win_d [8:0];

    logic win_valid_q, win_valid_d;
    logic win_last_q, win_last_d;

    logic stall;
    logic accept;
    logic col_end;
    logic row_end;
    logic emit;

    always_comb begin
        stall    = win_valid_q && !win_ready;
        in_ready = !stall;
        accept   = in_valid && in_ready;
        col_end  = (col_q == ColW'(IMG_WIDTH - 1));
        row_end  = (row_q == RowW'(IMG_HEIGHT - 1));
        emit     = accept && (row_q >= RowW'(2)) && (col_q >= ColW'(2));
    end

    // Raster position of the pixel currently being offered.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
        end
    end

    // Rows top..bottom map to sr[0..2], sr[3..5], sr[6..8]; the oldest column is leftmost.
    always_comb begin
        sr_d = sr_q;
        if (accept) begin
            sr_d[0] = sr_q[1];
            sr_d[1] = sr_q[2];
            sr_d[2] = lb1_q[col_q];
            sr_d[3] = sr_q[4];
            sr_d[4] = sr_q[5];
            sr_d[5] = lb0_q[col_q];
            sr_d[6] = sr_q[7];
            sr_d[7] = sr_q[8];
            sr_d[8] = in_pixel;
        end
    end

    always_comb begin
        win_d       = win_q;
        win_valid_d = win_valid_q;
        win_last_d  = win_last_q;
        if (!stall) begin
            win_valid_d = emit;
            win_last_d  = emit && row_end && col_end;
            if (emit) begin
                win_d = sr_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            win_q       <= win_d;
        end
    end

    // Storage is rewritten before it is ever emitted, so it needs no reset.
    always_ff @(posedge clk) begin
        sr_q <= sr_d;
        if (accept) begin
            lb1_q[col_q] <= lb0_q[col_q];
            lb0_q[col_q] <= in_pixel;
        end
    end

    assign win       = win_q;
    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;

endmodule
